// File: rtl/vram_arbiter_pkg.sv
// rtl/vram_arbiter_pkg.sv - shared types and framebuffer constants for the VRAM arbiter
package vram_arbiter_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;

    // Framebuffer window cleared by the clear engine
    localparam logic [ADDR_W-1:0] FB_BASE  = 12'hF00;
    localparam int                FB_BYTES = 256;

    // Owner of the RAM access travelling down the read pipeline
    typedef enum logic [2:0] {
        SRC_NONE,
        SRC_VGA,
        SRC_CPU_RD,
        SRC_CPU_WR,
        SRC_CLR
    } src_t;

    typedef enum logic [1:0] {
        CLR_IDLE,
        CLR_RUN,
        CLR_DRAIN
    } clr_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              we;
        logic [DATA_W-1:0] wdata;
    } ram_cmd_t;

    function automatic logic [ADDR_W-1:0] fb_addr(input logic [7:0] offset);
        return FB_BASE + {{(ADDR_W-8){1'b0}}, offset};
    endfunction

endpackage

// File: rtl/vram_clear_seq.sv
// rtl/vram_clear_seq.sv - framebuffer clear sequencer: one zero byte per free RAM slot
// Offset advances only in cycles where the arbiter hands it the RAM.
module vram_clear_seq
    import vram_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              slot_free,
    output logic              busy,
    output logic              wr_pending,
    output logic [ADDR_W-1:0] wr_addr
);

    localparam logic [7:0] LAST_OFF = 8'(FB_BYTES - 1);

    clr_state_t state, state_nxt;
    logic [7:0] offset, offset_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= CLR_IDLE;
            offset <= '0;
        end else begin
            state  <= state_nxt;
            offset <= offset_nxt;
        end
    end

    // DRAIN keeps busy high for the cycle the last write sits on the RAM port
    always_comb begin
        state_nxt  = state;
        offset_nxt = offset;
        wr_pending = 1'b0;
        busy       = (state != CLR_IDLE);
        case (state)
            CLR_IDLE: begin
                if (start) begin
                    state_nxt  = CLR_RUN;
                    offset_nxt = '0;
                end
            end
            CLR_RUN: begin
                wr_pending = 1'b1;
                if (slot_free) begin
                    offset_nxt = offset + 8'd1;
                    if (offset == LAST_OFF) begin
                        state_nxt = CLR_DRAIN;
                    end
                end
            end
            CLR_DRAIN: begin
                state_nxt = CLR_IDLE;
            end
            default: begin
                state_nxt = CLR_IDLE;
            end
        endcase
    end

    assign wr_addr = fb_addr(offset);

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter, fixed priority VGA > clear > CPU, 3-cycle read pipeline
// Clear engine (vram_clear_seq) is built only when VRAM_CLEAR_EN is defined.
module vram_arbiter
    import vram_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              vga_req,
    input  logic [ADDR_W-1:0] vga_addr,
    output logic [DATA_W-1:0] vga_data,
    output logic              vga_valid,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    logic              clr_pending;
    logic [ADDR_W-1:0] clr_addr;
    logic              cpu_busy;
    ram_cmd_t          cmd_nxt;
    src_t              src_nxt;
    src_t              p1_src;
    src_t              p2_src;

`ifdef VRAM_CLEAR_EN
    vram_clear_seq u_clear_seq (
        .clk        (clk),
        .rst        (rst),
        .start      (clr_start),
        .slot_free  (!vga_req),
        .busy       (clr_busy),
        .wr_pending (clr_pending),
        .wr_addr    (clr_addr)
    );
`else
    logic unused_clr_start;
    assign unused_clr_start = clr_start;
    assign clr_busy         = 1'b0;
    assign clr_pending      = 1'b0;
    assign clr_addr         = '0;
`endif

    // One CPU transaction in flight: blocked from grant until its ack cycle has passed
    assign cpu_busy = (p1_src inside {SRC_CPU_RD, SRC_CPU_WR}) ||
                      (p2_src inside {SRC_CPU_RD, SRC_CPU_WR}) ||
                      cpu_ack;

    always_comb begin
        cmd_nxt = '0;
        src_nxt = SRC_NONE;
        if (vga_req) begin
            cmd_nxt.addr = vga_addr;
            src_nxt      = SRC_VGA;
        end else if (clr_pending) begin
            cmd_nxt.addr = clr_addr;
            cmd_nxt.we   = 1'b1;
            src_nxt      = SRC_CLR;
        end else if (cpu_req && !clr_busy && !cpu_busy) begin
            cmd_nxt.addr = cpu_addr;
            if (cpu_we) begin
                cmd_nxt.we    = 1'b1;
                cmd_nxt.wdata = cpu_wdata;
                src_nxt       = SRC_CPU_WR;
            end else begin
                src_nxt       = SRC_CPU_RD;
            end
        end
    end

    // p1: command on ram_*, p2: ram_rdata valid, then result registered out
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_addr  <= '0;
            ram_we    <= 1'b0;
            ram_wdata <= '0;
            p1_src    <= SRC_NONE;
            p2_src    <= SRC_NONE;
            vga_valid <= 1'b0;
            vga_data  <= '0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
        end else begin
            ram_addr  <= cmd_nxt.addr;
            ram_we    <= cmd_nxt.we;
            ram_wdata <= cmd_nxt.wdata;
            p1_src    <= src_nxt;
            p2_src    <= p1_src;
            vga_valid <= (p2_src == SRC_VGA);
            if (p2_src == SRC_VGA) begin
                vga_data <= ram_rdata;
            end
            cpu_ack <= (p2_src inside {SRC_CPU_RD, SRC_CPU_WR});
            if (p2_src == SRC_CPU_RD) begin
                cpu_rdata <= ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - randomized bench for vram_arbiter against a cycle-level reference model
module tb_vram_arbiter;

    localparam logic [11:0] FB = 12'hF00;

    typedef enum int {S_VV, S_VD, S_CA, S_CR, S_RA, S_RW, S_RD, S_BUSY, S_MEM} sig_e;

    logic        clk, rst;
    logic        vga_req, vga_valid, cpu_req, cpu_we, cpu_ack, clr_start, clr_busy, ram_we;
    logic [11:0] vga_addr, cpu_addr, ram_addr;
    logic [7:0]  vga_data, cpu_wdata, cpu_rdata, ram_wdata, ram_rdata;

    vram_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .vga_req   (vga_req),
        .vga_addr  (vga_addr),
        .vga_data  (vga_data),
        .vga_valid (vga_valid),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .clr_start (clr_start),
        .clr_busy  (clr_busy),
        .ram_addr  (ram_addr),
        .ram_we    (ram_we),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] pat(input int i);
        if (i == 'hF05) return 8'hA5;
        return 8'(i * 37 + 11);
    endfunction

    // Synchronous single-port RAM seen by the DUT
    logic [7:0] mem [4096];
    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = pat(i);
        ram_rdata = 8'h00;
        forever begin
            @(posedge clk);
            ram_rdata <= mem[ram_addr];
            if (ram_we) mem[ram_addr] <= ram_wdata;
        end
    end

    // Reference model: per edge, pick the winner and schedule its ram_* and result cycles
    int          cyc;
    logic [7:0]  ref_mem [4096];
    logic [11:0] e_addr [8];
    logic        e_we [8], e_wdchk [8], e_vv [8], e_ca [8], e_crd [8];
    logic [7:0]  e_wd [8], e_vd [8], e_cd [8];
    logic [7:0]  m_vdata, m_cdata;
    logic        m_busy;
    int          m_off, cpu_free;

    initial begin
        int   s, f, adr;
        logic busy_before, drop;
        cyc = 0; m_vdata = 0; m_cdata = 0; m_busy = 0; m_off = 0; cpu_free = 0;
        for (int i = 0; i < 4096; i++) ref_mem[i] = pat(i);
        for (int i = 0; i < 8; i++) begin
            e_addr[i] = 0; e_we[i] = 0; e_wd[i] = 0; e_wdchk[i] = 1;
            e_vv[i] = 0; e_ca[i] = 0; e_crd[i] = 0; e_vd[i] = 0; e_cd[i] = 0;
        end
        forever begin
            @(posedge clk);
            cyc++;
            s = cyc % 8;
            f = (cyc + 2) % 8;
            e_addr[s] = 0; e_we[s] = 0; e_wd[s] = 0; e_wdchk[s] = 1;
            if (rst) begin
                for (int i = 0; i < 8; i++) begin
                    e_vv[i] = 0; e_ca[i] = 0; e_crd[i] = 0;
                end
                m_vdata = 0; m_cdata = 0; m_busy = 0; m_off = 0; cpu_free = 0;
            end else begin
                if (e_vv[s]) m_vdata = e_vd[s];
                if (e_ca[s] && e_crd[s]) m_cdata = e_cd[s];
                e_vv[f] = 0; e_ca[f] = 0; e_crd[f] = 0;
                busy_before = m_busy;
                drop = m_busy && (m_off == 256);
                if (vga_req) begin
                    e_addr[s] = vga_addr;
                    e_vv[f]   = 1;
                    e_vd[f]   = ref_mem[vga_addr];
                end else if (m_busy && m_off < 256) begin
                    adr = FB + m_off;
                    e_addr[s] = 12'(adr);
                    e_we[s]   = 1;
                    ref_mem[adr] = 8'h00;
                    m_off++;
                end else if (cpu_req && !busy_before && cyc >= cpu_free) begin
                    e_addr[s] = cpu_addr;
                    e_ca[f]   = 1;
                    cpu_free  = cyc + 4;
                    if (cpu_we) begin
                        e_we[s] = 1;
                        e_wd[s] = cpu_wdata;
                        ref_mem[cpu_addr] = cpu_wdata;
                    end else begin
                        e_wdchk[s] = 0;
                        e_crd[f]   = 1;
                        e_cd[f]    = ref_mem[cpu_addr];
                    end
                end
                if (drop) m_busy = 0;
`ifdef VRAM_CLEAR_EN
                else if (!busy_before && clr_start) begin
                    m_busy = 1;
                    m_off  = 0;
                end
`endif
            end
        end
    end

    // Hand-computed expectations keyed by cycle
    int          lit_n;
    int          lit_cyc [1024];
    sig_e        lit_sig [1024];
    logic [11:0] lit_adr [1024];
    int          lit_val [1024];

    task automatic lit(input int c, input sig_e sg, input int a, input int v);
        lit_cyc[lit_n] = c;
        lit_sig[lit_n] = sg;
        lit_adr[lit_n] = 12'(a);
        lit_val[lit_n] = v;
        lit_n++;
    endtask

    function automatic string sig_name(input sig_e sg);
        case (sg)
            S_VV:    return "lit_vga_valid";
            S_VD:    return "lit_vga_data";
            S_CA:    return "lit_cpu_ack";
            S_CR:    return "lit_cpu_rdata";
            S_RA:    return "lit_ram_addr";
            S_RW:    return "lit_ram_we";
            S_RD:    return "lit_ram_wdata";
            S_BUSY:  return "lit_clr_busy";
            default: return "lit_mem_byte";
        endcase
    endfunction

    int n_chk, n_fail;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    initial begin
        int s, a;
        n_chk = 0;
        n_fail = 0;
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                s = cyc % 8;
                chk("ram_addr", int'(ram_addr), int'(e_addr[s]));
                chk("ram_we", int'(ram_we), int'(e_we[s]));
                if (e_wdchk[s]) chk("ram_wdata", int'(ram_wdata), int'(e_wd[s]));
                chk("vga_valid", int'(vga_valid), int'(e_vv[s]));
                chk("vga_data", int'(vga_data), int'(m_vdata));
                chk("cpu_ack", int'(cpu_ack), int'(e_ca[s]));
                chk("cpu_rdata", int'(cpu_rdata), int'(m_cdata));
                chk("clr_busy", int'(clr_busy), int'(m_busy));
                for (int k = 0; k < lit_n; k++) begin
                    if (lit_cyc[k] == cyc) begin
                        case (lit_sig[k])
                            S_VV:    a = int'(vga_valid);
                            S_VD:    a = int'(vga_data);
                            S_CA:    a = int'(cpu_ack);
                            S_CR:    a = int'(cpu_rdata);
                            S_RA:    a = int'(ram_addr);
                            S_RW:    a = int'(ram_we);
                            S_RD:    a = int'(ram_wdata);
                            S_BUSY:  a = int'(clr_busy);
                            default: a = int'(mem[lit_adr[k]]);
                        endcase
                        chk(sig_name(lit_sig[k]), a, lit_val[k]);
                    end
                end
            end
        end
    end

    task automatic wait_ack();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cpu_ack) break;
        end
        cpu_req = 1'b0;
    endtask

    task automatic cpu_op(input logic we, input logic [11:0] addr, input logic [7:0] wd);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        wait_ack();
    endtask

    task automatic fill_fb(input logic [7:0] v);
        for (int i = 0; i < 256; i++) cpu_op(1'b1, 12'(FB + i), v);
    endtask

    initial begin
        int c;
        rst = 1; vga_req = 0; vga_addr = 0; cpu_req = 0; cpu_we = 0;
        cpu_addr = 0; cpu_wdata = 0; clr_start = 0; lit_n = 0;
        repeat (3) @(negedge clk);
        c = cyc;
        lit(c + 1, S_VV, 0, 0); lit(c + 1, S_VD, 0, 0); lit(c + 1, S_CA, 0, 0);
        lit(c + 1, S_CR, 0, 0); lit(c + 1, S_RA, 0, 0); lit(c + 1, S_RW, 0, 0);
        lit(c + 1, S_RD, 0, 0); lit(c + 1, S_BUSY, 0, 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);

        c = cyc; vga_req = 1; vga_addr = 12'hF05;
        lit(c + 1, S_RA, 0, 'hF05); lit(c + 1, S_RW, 0, 0);
        lit(c + 2, S_VV, 0, 0); lit(c + 2, S_VD, 0, 0);
        lit(c + 3, S_VV, 0, 1); lit(c + 3, S_VD, 0, 'hA5);
        lit(c + 4, S_VV, 0, 0); lit(c + 4, S_VD, 0, 'hA5);
        @(negedge clk);
        vga_req = 0;
        repeat (4) @(negedge clk);

        c = cyc; vga_req = 1; vga_addr = FB;
        cpu_req = 1; cpu_we = 1; cpu_addr = 12'h200; cpu_wdata = 8'h3C;
        lit(c + 1, S_RA, 0, 'hF00); lit(c + 1, S_RW, 0, 0);
        lit(c + 2, S_RA, 0, 'h200); lit(c + 2, S_RW, 0, 1); lit(c + 2, S_RD, 0, 'h3C);
        lit(c + 3, S_VV, 0, 1); lit(c + 3, S_VD, 0, 'h0B); lit(c + 3, S_CA, 0, 0);
        lit(c + 4, S_CA, 0, 1); lit(c + 4, S_VV, 0, 0);
        @(negedge clk);
        vga_req = 0;
        wait_ack();
        repeat (2) @(negedge clk);

        c = cyc; cpu_req = 1; cpu_we = 1; cpu_addr = 12'h123; cpu_wdata = 8'h7E;
        lit(c + 1, S_RA, 0, 'h123); lit(c + 1, S_RW, 0, 1); lit(c + 1, S_RD, 0, 'h7E);
        lit(c + 2, S_CA, 0, 0); lit(c + 3, S_CA, 0, 1);
        wait_ack();
        @(negedge clk);
        c = cyc; cpu_req = 1; cpu_we = 0; cpu_addr = 12'h123;
        lit(c + 1, S_RA, 0, 'h123); lit(c + 1, S_RW, 0, 0);
        lit(c + 2, S_CA, 0, 0); lit(c + 3, S_CA, 0, 1); lit(c + 3, S_CR, 0, 'h7E);
        wait_ack();
        repeat (2) @(negedge clk);

`ifdef VRAM_CLEAR_EN
        fill_fb(8'hFF);
        @(negedge clk);
        c = cyc; clr_start = 1;
        lit(c + 1, S_BUSY, 0, 1);
        @(negedge clk);
        clr_start = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 12'h300; cpu_wdata = 8'h55;
        for (int i = 0; i < 700 && clr_busy; i++) begin
            @(negedge clk);
            vga_req  = ~vga_req;
            vga_addr = 12'(FB + $urandom_range(0, 255));
        end
        vga_req = 0;
        lit(cyc + 1, S_BUSY, 0, 0);
        wait_ack();
        @(negedge clk);
        c = cyc;
        for (int i = 0; i < 256; i++) lit(c + 1, S_MEM, FB + i, 0);
        repeat (2) @(negedge clk);

        fill_fb(8'hFF);
        @(negedge clk);
        clr_start = 1;
        @(negedge clk);
        clr_start = 0;
        for (int i = 0; i < 400; i++) begin
            if (ram_we && ram_addr == 12'hF3F) break;
            @(negedge clk);
        end
        c = cyc; rst = 1;
        lit(c + 1, S_BUSY, 0, 0); lit(c + 1, S_RW, 0, 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        c = cyc;
        for (int i = 0; i < 256; i++) lit(c + 1, S_MEM, FB + i, (i < 64) ? 0 : 'hFF);
        repeat (3) @(negedge clk);
`endif

        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            rst      = ($urandom_range(0, 499) == 0);
            vga_req  = 1'($urandom_range(0, 1));
            vga_addr = 12'($urandom_range(0, 31)) | (($urandom_range(0, 1) == 1) ? FB : 12'h100);
            if (cpu_req && cpu_ack) begin
                cpu_req = 0;
            end else if (!cpu_req && $urandom_range(0, 3) == 0) begin
                cpu_req   = 1;
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = 12'($urandom_range(0, 31)) | (($urandom_range(0, 1) == 1) ? FB : 12'h100);
                cpu_wdata = 8'($urandom_range(0, 255));
            end
            clr_start = ($urandom_range(0, 299) == 0);
        end

        rst = 0; vga_req = 0; cpu_req = 0; clr_start = 0;
        repeat (8) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
